// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: captures a word, pulses load, and walks the output mux through start/data/parity/stop.
// Optional one-word hold buffer for words arriving mid-frame: define UART_TX_HOLD_EN.
module uart_tx_ctrl #(
  parameter int DATA_WD = 8,
  parameter int CNT_WD  = $clog2(DATA_WD)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_WD-1:0] P_DATA,
  input  logic               Data_Valid,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic [DATA_WD-1:0] frame_data,
  output logic               load,
  output logic               par_typ_q,
  output logic               ser_en,
  output logic [1:0]         mux_sel,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [CNT_WD-1:0] LAST_BIT = CNT_WD'(DATA_WD - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_WD-1:0]  bit_cnt;
  logic               par_en_q;
  logic               frame_open;
  logic               capture;
  logic [DATA_WD-1:0] cap_data;
  logic               cap_par_en;
  logic               cap_par_typ;
  logic [1:0]         mux_sel_d;
  logic               busy_d;
  logic               ser_en_d;
  logic               load_d;

  // A new word may only start a frame from IDLE or during the stop bit.
  assign frame_open = (state == IDLE) || (state == STOP);

`ifdef UART_TX_HOLD_EN
  logic [DATA_WD-1:0] hold_data;
  logic               hold_par_en;
  logic               hold_par_typ;
  logic               hold_full;
  logic               in_body;
  logic               hold_store;

  assign in_body    = (state == START) || (state == DATA) || (state == PARITY);
  assign hold_store = Data_Valid && in_body && !hold_full;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_full <= 1'b0;
    end else if (hold_full) begin
      if (state == STOP) hold_full <= 1'b0;
    end else if (hold_store) begin
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (hold_store) begin
      hold_data    <= P_DATA;
      hold_par_en  <= PAR_EN;
      hold_par_typ <= PAR_TYP;
    end
  end

  // The held word wins over a simultaneous Data_Valid in STOP.
  assign capture     = frame_open && (hold_full || Data_Valid);
  assign cap_data    = hold_full ? hold_data    : P_DATA;
  assign cap_par_en  = hold_full ? hold_par_en  : PAR_EN;
  assign cap_par_typ = hold_full ? hold_par_typ : PAR_TYP;
`else
  assign capture     = frame_open && Data_Valid;
  assign cap_data    = P_DATA;
  assign cap_par_en  = PAR_EN;
  assign cap_par_typ = PAR_TYP;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      frame_data <= '0;
      mux_sel    <= 2'b11;
      busy       <= 1'b0;
      ser_en     <= 1'b0;
      load       <= 1'b0;
    end else begin
      state   <= next_state;
      mux_sel <= mux_sel_d;
      busy    <= busy_d;
      ser_en  <= ser_en_d;
      load    <= load_d;
      if ((state == DATA) && (bit_cnt != LAST_BIT)) bit_cnt <= bit_cnt + CNT_WD'(1);
      else                                          bit_cnt <= '0;
      if (capture) begin
        frame_data <= cap_data;
        par_en_q   <= cap_par_en;
        par_typ_q  <= cap_par_typ;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (capture) next_state = START;
      START:   next_state = DATA;
      DATA:    if (bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
      PARITY:  next_state = STOP;
      STOP:    next_state = capture ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so they line up with the state they describe.
  always_comb begin
    mux_sel_d = 2'b11;
    busy_d    = 1'b1;
    ser_en_d  = 1'b0;
    load_d    = 1'b0;
    case (next_state)
      IDLE:    busy_d = 1'b0;
      START: begin
        mux_sel_d = 2'b00;
        load_d    = 1'b1;
      end
      DATA: begin
        mux_sel_d = 2'b01;
        ser_en_d  = 1'b1;
      end
      PARITY:  mux_sel_d = 2'b10;
      STOP:    mux_sel_d = 2'b11;
      default: busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected frames, a negedge monitor checks every cycle.
module tb_uart_tx_ctrl;

  localparam int DATA_WD = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       pt;
  } frm_t;

  logic               CLK;
  logic               RST;
  logic [DATA_WD-1:0] P_DATA;
  logic               Data_Valid;
  logic               PAR_EN;
  logic               PAR_TYP;
  logic [DATA_WD-1:0] frame_data;
  logic               load;
  logic               par_typ_q;
  logic               ser_en;
  logic [1:0]         mux_sel;
  logic               busy;

  int   checks   = 0;
  int   failures = 0;
  frm_t exp_q[$];
  logic mon_en;

  uart_tx_ctrl #(.DATA_WD(DATA_WD)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .frame_data(frame_data), .load(load),
    .par_typ_q(par_typ_q), .ser_en(ser_en), .mux_sel(mux_sel), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic pt);
    frm_t f;
    f.d  = d;
    f.pe = pe;
    f.pt = pt;
    exp_q.push_back(f);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
  endtask

  // Monitor: a load pulse opens the next expected frame; every cycle is then checked against it.
  initial begin
    frm_t        cur;
    int          k;
    int          len;
    logic        in_frame;
    logic [13:0] act;
    logic [13:0] req;
    logic [1:0]  m;
    logic        s;
    logic        l;
    in_frame = 1'b0;
    k        = 0;
    len      = 0;
    cur      = '0;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && load) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_load actual frame_data=%h required=no frame", frame_data);
          end else begin
            cur      = exp_q.pop_front();
            in_frame = 1'b1;
            k        = 0;
            len      = DATA_WD + 2 + int'(cur.pe);
          end
        end
        if (in_frame) begin
          if (k == 0)                             begin m = 2'b00; s = 1'b0; l = 1'b1; end
          else if (k <= DATA_WD)                  begin m = 2'b01; s = 1'b1; l = 1'b0; end
          else if (cur.pe && (k == DATA_WD + 1))  begin m = 2'b10; s = 1'b0; l = 1'b0; end
          else                                    begin m = 2'b11; s = 1'b0; l = 1'b0; end
          act = {mux_sel, ser_en, load, busy, par_typ_q, frame_data};
          req = {m, s, l, 1'b1, cur.pt, cur.d};
          chk($sformatf("frame_%h_cycle%0d", cur.d, k), 32'(act), 32'(req));
          k++;
          if (k == len) in_frame = 1'b0;
        end else if (!load) begin
          chk("idle", 32'({mux_sel, busy, ser_en, load}), 32'({2'b11, 3'b000}));
        end
      end
    end
  end

  initial begin
    RST        = 1'b1;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    mon_en     = 1'b0;
    #2;
    chk("reset_state", 32'({mux_sel, busy, ser_en, load, par_typ_q, frame_data}),
        32'({2'b11, 4'b0000, 8'h00}));
    cyc(3);
    RST = 1'b0;
    cyc(1);
    mon_en = 1'b1;
    cyc(20);

    // Parity frame, even.
    expect_frame(8'hA5, 1'b1, 1'b0);
    pulse(8'hA5, 1'b1, 1'b0);
    cyc(15);

    // No parity; config changes mid-frame must not leak in.
    expect_frame(8'h3C, 1'b0, 1'b1);
    pulse(8'h3C, 1'b0, 1'b1);
    cyc(3);
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    cyc(12);

    // Data_Valid held high; second word presented during STOP.
    expect_frame(8'h11, 1'b0, 1'b0);
`ifdef UART_TX_HOLD_EN
    expect_frame(8'h11, 1'b0, 1'b0);
`else
    expect_frame(8'h22, 1'b0, 1'b0);
`endif
    P_DATA     = 8'h11;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    cyc(1);
    cyc(9);
    P_DATA = 8'h22;
    cyc(1);
    Data_Valid = 1'b0;
    cyc(25);

    // Reset in the 4th DATA cycle aborts the frame at once.
    mon_en = 1'b0;
    pulse(8'h77, 1'b1, 1'b1);
    cyc(4);
    chk("pre_reset_data", 32'({mux_sel, ser_en, busy}), 32'({2'b01, 2'b11}));
    #1;
    RST = 1'b1;
    #1;
    chk("reset_abort", 32'({mux_sel, busy, ser_en, load}), 32'({2'b11, 3'b000}));
    #1;
    RST = 1'b0;
    cyc(1);
    mon_en = 1'b1;
    expect_frame(8'h96, 1'b1, 1'b1);
    pulse(8'h96, 1'b1, 1'b1);
    cyc(15);

    // Word arriving mid-frame, then a third word.
    expect_frame(8'h0F, 1'b0, 1'b0);
    pulse(8'h0F, 1'b0, 1'b0);
    cyc(1);
`ifdef UART_TX_HOLD_EN
    expect_frame(8'h55, 1'b1, 1'b1);
`endif
    pulse(8'h55, 1'b1, 1'b1);
    cyc(1);
    pulse(8'hC3, 1'b0, 1'b0);
    cyc(30);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter; sits between the system-side data source and the TX datapath (serializer, parity calculator, output mux).
- Captures a word on Data_Valid and issues the load strobe for the serializer and parity calculator.
- Steps the output mux through start, data, parity and stop bits, one bit per CLK, and drives busy.
- CLK is the already-divided TX bit clock.

Parameters:
- DATA_WD, 8, data bits per frame (supported 5..9).
- CNT_WD, $clog2(DATA_WD), width of the internal data-bit counter.

Ports:
- CLK  input  1  TX bit clock.
- RST  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_WD  word to transmit.
- Data_Valid  input  1  P_DATA valid; single-cycle or held.
- PAR_EN  input  1  1 = insert parity bit; sampled at capture.
- PAR_TYP  input  1  0 even, 1 odd; sampled at capture.
- frame_data  output  DATA_WD  captured word, stable for the whole frame.
- load  output  1  one-cycle strobe; serializer and parity calc latch frame_data.
- par_typ_q  output  1  captured PAR_TYP, to the parity calc.
- ser_en  output  1  serializer shift enable, high during data bits.
- mux_sel  output  2  00 start(0), 01 serial data, 10 parity, 11 stop/idle(1).
- busy  output  1  frame in progress.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, mux_sel=11, busy=0, ser_en=0, load=0, frame_data=0, par_typ_q=0, bit_cnt=0, captured par_en=0.
  - Asserting RST mid-frame aborts the frame immediately; the line returns to 1 (mux_sel=11) with no partial stop bit.
- All outputs are registered; no combinational path from inputs to outputs.
- Capture condition: Data_Valid=1 with state IDLE, or with state STOP (back-to-back).
  - On capture: frame_data<=P_DATA, cfg<={PAR_EN,PAR_TYP}, load<=1 for exactly one cycle, state<=START.
- States (one CLK each unless noted):
  - IDLE: mux_sel=11, busy=0, ser_en=0. Capture -> START; else stay.
  - START: mux_sel=00, busy=1, load=1. -> DATA with bit_cnt=0.
  - DATA: mux_sel=01, ser_en=1, busy=1, bit_cnt++ each cycle. Lasts DATA_WD cycles. At bit_cnt=DATA_WD-1: -> PARITY if captured par_en, else -> STOP.
  - PARITY: mux_sel=10, ser_en=0, busy=1. -> STOP.
  - STOP: mux_sel=11, busy=1. Capture -> START; else -> IDLE.
- Latency and length:
  - Capture cycle to first start bit on the mux: 1 CLK.
  - Frame length: DATA_WD+2+PAR_EN cycles.
  - Back-to-back frames have no idle gap.
- Data_Valid while busy outside STOP is ignored (word dropped).
- PAR_EN/PAR_TYP changes mid-frame have no effect until the next capture.
- bit_cnt compares against DATA_WD-1 exactly; no wrap beyond DATA_WD-1.
- Downstream parity calc latches on load and registers par_bit one cycle later; par_bit is valid well before PARITY.

Optional Feature:
- Macro: UART_TX_HOLD_EN.
- Defined:
  - One-entry hold buffer (data + cfg + hold_full flag).
  - Data_Valid while busy in START/DATA/PARITY with hold_full=0 stores the word; hold_full<=1.
  - In STOP with hold_full=1, the held word is captured (load pulse, -> START) and hold_full clears. The held word has priority over a simultaneous Data_Valid, which is then dropped.
  - Data_Valid with hold_full=1 is dropped.
  - Reset clears hold_full.
- Undefined: no buffer; behaviour exactly as described in Behaviour.

Test Plan:
- Reset then idle, DATA_WD=8 -> mux_sel=11, busy=0, load=0, ser_en=0 held indefinitely.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle Data_Valid -> load pulse in START, mux_sel sequence 00, 01x8 (ser_en high 8 cycles), 10, 11; busy high 11 cycles, then IDLE.
- P_DATA=0x3C, PAR_EN=0 -> no PARITY state, busy high 10 cycles, frame_data=0x3C throughout.
- Data_Valid held high, words 0x11 then 0x22 presented in the STOP cycle -> second START immediately after STOP, zero idle cycles, second load pulse.
- RST asserted in the 4th DATA cycle -> same-cycle mux_sel=11, busy=0, ser_en=0; next Data_Valid starts a clean frame.
- With UART_TX_HOLD_EN: pulse 0x55 during DATA of frame 0x0F, then a third word -> 0x55 sent back-to-back after STOP, third word dropped; without the macro 0x55 is dropped.
